// File: rtl/b16dot_ctrl.sv
// b16dot_ctrl: sequences a single-lane BF16 MAC as a command-driven dot-product engine.
// A length command clears the MAC accumulator and streams that many operand pairs into it.
// The block then waits out the MAC pipeline and returns the final sum on a result handshake.
module b16dot_ctrl #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAC_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    // operand stream
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    // MAC instance pins
    output logic             mac_rst,
    output logic             mac_valid,
    output logic [15:0]      mac_opra,
    output logic [15:0]      mac_oprb,
    input  logic [15:0]      mac_result,
    // result channel
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             busy
);

    // Wide enough to hold MAC_LAT; MAC_LAT is expected to be at least 1.
    localparam int unsigned DRN_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StResult
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic [15:0]        res_data_q, res_data_d;

    // State and datapath registers; reset discards any partial or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            drain_q    <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            drain_q    <= drain_d;
            res_data_q <= res_data_d;
        end
    end

    // Next-state logic: one command in flight, CLEAR always precedes streaming.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        drain_d    = drain_q;
        res_data_d = res_data_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    count_d = cmd_len;
                    state_d = StClear;
                end
            end
            StClear: begin
                // A zero-length command still waits the MAC latency so the
                // cleared accumulator (0x0000) is what gets returned.
                if (count_q == '0) begin
                    drain_d = DRN_W'(MAC_LAT);
                    state_d = StDrain;
                end else begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (in_valid) begin
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        drain_d = DRN_W'(MAC_LAT);
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                drain_d = drain_q - DRN_W'(1);
                if (drain_q == DRN_W'(1)) begin
                    res_data_d = mac_result;
                    state_d    = StResult;
                end
            end
            StResult: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode; operands pass straight through to the MAC only while streaming.
    always_comb begin
        cmd_ready = rst_n && (state_q == StIdle);
        in_ready  = (state_q == StStream);
        mac_valid = (state_q == StStream) && in_valid;
        mac_opra  = (state_q == StStream) ? in_a : 16'h0000;
        mac_oprb  = (state_q == StStream) ? in_b : 16'h0000;
        // Held high through reset so the MAC comes out of it cleared.
        mac_rst   = !rst_n || (state_q == StClear);
        res_valid = (state_q == StResult);
        res_data  = res_data_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_b16dot_ctrl.sv
// tb_b16dot_ctrl: directed bench for b16dot_ctrl with a behavioural BF16 MAC model
// and a queue of expected dot-product results.
module tb_b16dot_ctrl;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned MAC_LAT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             mac_rst;
    logic             mac_valid;
    logic [15:0]      mac_opra;
    logic [15:0]      mac_oprb;
    logic [15:0]      mac_result;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mv_cnt   = 0;
    int ir_cnt   = 0;
    int acc_cyc  = 0;
    int mv0, ir0;

    logic [15:0] exp_q[$];
    logic [15:0] a3[3];
    logic [15:0] b3[3];

    always #5 clk = ~clk;

    b16dot_ctrl #(
        .LEN_W   (LEN_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mac_rst    (mac_rst),
        .mac_valid  (mac_valid),
        .mac_opra   (mac_opra),
        .mac_oprb   (mac_oprb),
        .mac_result (mac_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy)
    );

    // BF16 <-> real conversion for normal numbers and zero (enough for the test vectors).
    function automatic real bf2r(input logic [15:0] x);
        logic [63:0] d;
        if (x[14:0] == 15'd0) d = {x[15], 63'd0};
        else d = {x[15], 11'(x[14:7]) - 11'd127 + 11'd1023, x[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 15'd0};
        e = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], e[7:0], d[51:45]};
    endfunction

    // MAC model: sum updates on the edge sampling valid; Result visible MAC_LAT-1 edges later,
    // so the edge MAC_LAT after the last valid samples the final sum.
    logic [15:0] m_acc, m_d1, m_d2, m_d3;
    always @(posedge clk) begin
        if (mac_rst) begin
            m_acc <= 16'h0; m_d1 <= 16'h0; m_d2 <= 16'h0; m_d3 <= 16'h0;
        end else begin
            if (mac_valid) m_acc <= r2bf(bf2r(m_acc) + bf2r(mac_opra) * bf2r(mac_oprb));
            m_d1 <= m_acc; m_d2 <= m_d1; m_d3 <= m_d2;
        end
    end
    assign mac_result = m_d3;

    // Cycle counter and activity monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_valid) mv_cnt <= mv_cnt + 1;
        if (in_ready)  ir_cnt <= ir_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_mac_valid"}, 32'(mac_valid), 32'd0);
        chk({tag, "_mac_opra"},  32'(mac_opra),  32'd0);
        chk({tag, "_mac_oprb"},  32'(mac_oprb),  32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_res_data"},  32'(res_data),  32'd0);
        chk({tag, "_mac_rst"},   32'(mac_rst),   32'd1);
    endtask

    // Offer a command from IDLE; records the accept edge and pushes the expected sum.
    task automatic issue(input logic [LEN_W-1:0] len, input logic [15:0] exp);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_len   = len;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        exp_q.push_back(exp);
    endtask

    // Stream n beats from a3/b3 with gap idle cycles after each beat.
    task automatic send(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int w;
            w        = 0;
            in_valid = 1'b1;
            in_a     = a3[i];
            in_b     = b3[i];
            @(negedge clk);
            while (!in_ready && w < 50) begin
                w++;
                @(negedge clk);
            end
            chk("in_ready_seen", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_a     = 16'h0;
            in_b     = 16'h0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Wait (bounded) for res_valid; exp_edges counts edges after the accept edge (-1: skip).
    task automatic wait_res(input string tag, input int exp_edges);
        int w;
        w = 0;
        @(negedge clk);
        while (!res_valid && w < 200) begin
            w++;
            @(negedge clk);
        end
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        if (exp_edges >= 0) chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_edges));
    endtask

    // Called at a negedge with res_valid high: compare, consume, confirm return to IDLE.
    task automatic take_res(input string tag);
        logic [15:0] e;
        e = exp_q.pop_front();
        chk({tag, "_data"}, 32'(res_data), 32'(e));
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_a      = 16'h0;
        in_b      = 16'h0;
        res_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;

        // Basic: 1*2 + 2*2 + 3*2 = 12.0. RESULT is the (N+MAC_LAT+2)th cycle after the
        // accept edge: 1 CLEAR + N STREAM + MAC_LAT DRAIN edges, then res_valid.
        a3 = '{16'h3F80, 16'h4000, 16'h4040};
        b3 = '{16'h4000, 16'h4000, 16'h4000};
        issue(8'd3, 16'h4140);
        send(3, 0);
        wait_res("basic", 3 + MAC_LAT + 1);
        take_res("basic");

        // Zero length: no operand traffic, cleared accumulator after CLEAR + MAC_LAT cycles
        mv0 = mv_cnt;
        ir0 = ir_cnt;
        issue(8'd0, 16'h0000);
        wait_res("zero", 0 + MAC_LAT + 1);
        chk("zero_mac_valid_cnt", 32'(mv_cnt - mv0), 32'd0);
        chk("zero_in_ready_cnt",  32'(ir_cnt - ir0), 32'd0);
        take_res("zero");

        // Bubbles: two idle cycles between beats, still exactly three MAC beats
        mv0 = mv_cnt;
        issue(8'd3, 16'h4140);
        send(3, 2);
        wait_res("bubble", -1);
        chk("bubble_mac_valid_cnt", 32'(mv_cnt - mv0), 32'd3);
        take_res("bubble");

        // Back-pressure: result held, no command accepted while RESULT waits
        issue(8'd3, 16'h4140);
        send(3, 0);
        wait_res("bp", 3 + MAC_LAT + 1);
        cmd_valid = 1'b1;
        cmd_len   = 8'd5;
        for (int k = 0; k < 10; k++) begin
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_res_data",  32'(res_data),  32'(exp_q[0]));
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        take_res("bp");

        // Back-to-back isolation: 2*2 = 4.0, then 1*1 = 1.0 (not 5.0)
        a3[0] = 16'h4000;
        b3[0] = 16'h4000;
        issue(8'd1, 16'h4080);
        send(1, 0);
        wait_res("b2b1", 1 + MAC_LAT + 1);
        take_res("b2b1");
        a3[0] = 16'h3F80;
        b3[0] = 16'h3F80;
        issue(8'd1, 16'h3F80);
        send(1, 0);
        wait_res("b2b2", 1 + MAC_LAT + 1);
        take_res("b2b2");

        // Reset mid-stream after the 2nd beat; outputs drop at once, pending result dropped
        a3 = '{16'h3F80, 16'h4000, 16'h4040};
        b3 = '{16'h4000, 16'h4000, 16'h4000};
        issue(8'd3, 16'h4140);
        send(2, 0);
        in_valid = 1'b1;
        in_a     = a3[2];
        in_b     = b3[2];
        rst_n    = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        in_valid = 1'b0;
        in_a     = 16'h0;
        in_b     = 16'h0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First command after release: 3.0 * 0.5 = 1.5
        a3[0] = 16'h4040;
        b3[0] = 16'h3F00;
        issue(8'd1, 16'h3FC0);
        send(1, 0);
        wait_res("postrst", 1 + MAC_LAT + 1);
        take_res("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/b16dot_ctrl.md
# b16dot_ctrl

Sequencer that turns the single-lane BFLOAT16 MAC datapath into a command-driven dot-product engine. It accepts a length command, clears the MAC accumulator, and streams exactly that many operand pairs into the MAC. It then waits out the MAC pipeline latency and returns the final accumulated sum on a result handshake. It sits between the operand fetch logic (vector buffers) and the MAC instance, and owns that instance's `rst`, `valid`, `oprA` and `oprB` pins.

## Interface
- LEN_W, 8, width of the command length field (max dot-product length 2^LEN_W-1)
- MAC_LAT, 4, clock edges from the edge that samples the last `mac_valid` to the edge at which `mac_result` holds the final sum; 4 for the current MAC
- clk  in  1  single clock, all logic posedge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_len  in  LEN_W  number of operand pairs; 0 is legal
- in_valid  in  1  operand pair offered
- in_ready  out  1  operand pair accepted when both high
- in_a  in  16  BF16 operand A
- in_b  in  16  BF16 operand B
- mac_rst  out  1  to MAC `rst` (sync, active-high accumulator clear)
- mac_valid  out  1  to MAC `valid`
- mac_opra  out  16  to MAC `oprA`
- mac_oprb  out  16  to MAC `oprB`
- mac_result  in  16  from MAC `Result`
- res_valid  out  1  dot-product result available
- res_ready  in  1  result consumed when both high
- res_data  out  16  BF16 dot-product result
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, RESULT. Registers: state, remaining count (LEN_W), drain counter, res_data.
- **IDLE:** `cmd_ready`=1. On `cmd_valid` latch `cmd_len` into count, then go to CLEAR.
- **CLEAR:** one cycle, `mac_rst`=1. Then go to DRAIN if count==0, else STREAM.
- **STREAM:**
  - `in_ready`=1, `mac_valid`=`in_valid`, and `mac_opra`/`mac_oprb` = `in_a`/`in_b` combinationally.
  - Each accepted beat decrements count.
  - A beat accepted with count==1 moves to DRAIN and loads the drain counter with MAC_LAT.
  - `in_valid` gaps are legal bubbles: `mac_valid`=0 and the MAC holds its sum.
- **DRAIN:**
  - `in_ready`=0. The drain counter decrements each cycle.
  - At the edge where the counter==1, capture `mac_result` into `res_data` and go to RESULT.
  - The len==0 path also waits MAC_LAT cycles, so `res_data` = 0x0000, the cleared accumulator.
- **RESULT:** `res_valid`=1 and `res_data` is held stable. On `res_ready` go to IDLE.
- Outside STREAM: `mac_valid`=0, `mac_opra`=`mac_oprb`=0x0000, `in_ready`=0.
- Only one command is in flight. `cmd_ready` is 0 in every state except IDLE, so no command is accepted in the RESULT handoff cycle.
- No arithmetic is done here. Rounding, overflow and NaN are whatever the MAC produces; `res_data` is passed through bit-exact.

## Timing
- Reset, asynchronous: state goes to IDLE, count/drain/`res_data` go to 0.
  - While `rst_n`=0: `cmd_ready`=0, `in_ready`=0, `mac_valid`=0, `mac_opra`=`mac_oprb`=0, `res_valid`=0, `busy`=0, `res_data`=0.
  - `mac_rst`=1 (it is `~rst_n | state==CLEAR`), which keeps the MAC cleared.
- Reset mid-operation: partial sum and pending result are discarded. The first command after release starts from a clean accumulator.
- Command latency, len=N with no bubbles: accept edge → 1 CLEAR cycle → N STREAM cycles → MAC_LAT DRAIN cycles. `res_valid` rises N+MAC_LAT+2 cycles after the accept edge.
- Minimum command-to-command spacing is N+MAC_LAT+3 cycles, including 1 IDLE cycle.
- The CLEAR edge clears MAC `sum_reg` and `im_valid` before the first STREAM beat is sampled.

## Test plan
- **Basic dot product:** len=3, A=[0x3F80,0x4000,0x4040], B=[0x4000,0x4000,0x4000] with no bubbles → `res_data`=0x4140 (12.0). `res_valid` rises 3+MAC_LAT+2 cycles after cmd accept.
- **Zero length:** len=0 → no `in_ready` ever, `mac_valid` never high, `res_data`=0x0000 after 1+MAC_LAT cycles.
- **Bubbles:** same vectors as the basic test with `in_valid` dropped for 2 cycles between each beat → `res_data`=0x4140, exactly 3 `mac_valid` pulses.
- **Back-pressure:** `res_ready` held low 10 cycles in RESULT → `res_valid` stays 1, `res_data` stable, `cmd_ready`=0 throughout.
- **Back-to-back isolation:** cmd len=1 with 0x4000×0x4000, result → 0x4080. Then cmd len=1 with 0x3F80×0x3F80 → 0x3F80, not 0x40A0, proving the accumulator is cleared.
- **Reset mid-stream:** assert `rst_n`=0 after the 2nd beat of a len=3 command → all outputs take their reset values immediately and `mac_rst`=1. After release, len=1 with 0x4040×0x3F00 → 0x3FC0 (1.5).
